// File: rtl/obi_arb_pkg.sv
// Shared types and constants for the OBI round-robin arbiter.
// Holds the arbiter state encoding and the saturating error-counter helper.
package obi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    RESP = 2'b10
  } arb_state_e;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  function automatic logic [ERR_CNT_W-1:0] err_cnt_sat_inc(input logic [ERR_CNT_W-1:0] cnt);
    return (cnt == ERR_CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/obi_rr_select.sv
// Combinational round-robin picker: first set request at or after the priority
// index, wrapping modulo NUM_REQ.
module obi_rr_select #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_prio,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx,
  output logic [NUM_REQ-1:0] o_onehot
);

  always_comb begin
    int                 k;
    logic [IDX_W-1:0]   kk;
    o_valid  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    k        = 0;
    kk       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(i_prio) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      kk = IDX_W'(k);
      if (!o_valid && i_req[kk]) begin
        o_valid = 1'b1;
        o_idx   = kk;
      end
    end
    if (o_valid) o_onehot[o_idx] = 1'b1;
  end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI manager port among NUM_REQ requesters,
// one outstanding transaction at a time, with response routing and error count.
module obi_rr_arbiter
  import obi_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = $clog2(NUM_REQ),
  localparam int BE_W       = DATA_WIDTH / 8
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_REQ*BE_W-1:0]       be_i,
  input  logic [NUM_REQ-1:0]            rready_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          err_o,
  output logic                          obi_req_o,
  output logic                          obi_we_o,
  output logic [ADDR_WIDTH-1:0]         obi_addr_o,
  output logic [DATA_WIDTH-1:0]         obi_wdata_o,
  output logic [BE_W-1:0]               obi_be_o,
  input  logic                          obi_gnt_i,
  input  logic                          obi_rvalid_i,
  output logic                          obi_rready_o,
  input  logic [DATA_WIDTH-1:0]         obi_rdata_i,
  input  logic                          obi_err_i,
  output logic [IDX_W-1:0]              owner_o,
  output logic                          busy_o,
  output logic [ERR_CNT_W-1:0]          err_cnt_o
);

  arb_state_e             r_state;
  arb_state_e             w_state_d;
  logic [IDX_W-1:0]       r_prio;
  logic [IDX_W-1:0]       r_owner;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  logic                   w_win_valid;
  logic [IDX_W-1:0]       w_win_idx;
  logic [NUM_REQ-1:0]     w_win_oh;
  logic [NUM_REQ-1:0]     w_own_oh;
  logic                   w_own_rready;
  logic                   w_use_win;
  logic [IDX_W-1:0]       w_sel_idx;
  logic                   w_sel_we;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [DATA_WIDTH-1:0]  w_sel_wdata;
  logic [BE_W-1:0]        w_sel_be;
  logic                   w_req;
  logic                   w_rready;
  logic                   w_resp_done;
  logic [NUM_REQ-1:0]     w_gnt;
  logic [NUM_REQ-1:0]     w_rvalid;

  obi_rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_select (
    .i_req    (req_i),
    .i_prio   (r_prio),
    .o_valid  (w_win_valid),
    .o_idx    (w_win_idx),
    .o_onehot (w_win_oh)
  );

  assign w_own_oh     = NUM_REQ'(1) << r_owner;
  assign w_own_rready = rready_i[r_owner];

  // In IDLE the downstream fields follow the fresh winner; afterwards they stay
  // with the registered owner so late requests from others cannot disturb them.
  assign w_sel_idx = w_use_win ? w_win_idx : r_owner;

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == w_sel_idx) begin
        w_sel_we    = we_i[k];
        w_sel_addr  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        w_sel_be    = be_i[k*BE_W +: BE_W];
      end
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_gnt       = '0;
    w_rvalid    = '0;
    w_req       = 1'b0;
    w_rready    = 1'b1;
    w_use_win   = 1'b0;
    w_resp_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_win_valid) begin
          w_req     = 1'b1;
          w_use_win = 1'b1;
          if (obi_gnt_i) begin
            w_gnt     = w_win_oh;
            w_state_d = RESP;
          end else begin
            w_state_d = ADDR;
          end
        end
      end
      ADDR: begin
        w_req = 1'b1;
        if (obi_gnt_i) begin
          w_gnt     = w_own_oh;
          w_state_d = RESP;
        end
      end
      RESP: begin
        w_rready = w_own_rready;
        if (obi_rvalid_i) w_rvalid = w_own_oh;
        if (obi_rvalid_i && w_own_rready) begin
          w_resp_done = 1'b1;
          w_state_d   = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state   <= IDLE;
      r_prio    <= '0;
      r_owner   <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == IDLE && w_win_valid) begin
        r_owner <= w_win_idx;
        r_prio  <= (int'(w_win_idx) == NUM_REQ - 1) ? '0 : w_win_idx + 1'b1;
      end
      if (w_resp_done && obi_err_i) r_err_cnt <= err_cnt_sat_inc(r_err_cnt);
    end
  end

  // Outputs are forced quiet while reset is asserted, whatever the state.
  assign gnt_o        = reset_ni ? w_gnt : '0;
  assign rvalid_o     = reset_ni ? w_rvalid : '0;
  assign obi_req_o    = reset_ni & w_req;
  assign obi_we_o     = reset_ni & w_req & w_sel_we;
  assign obi_addr_o   = (reset_ni && w_req) ? w_sel_addr : '0;
  assign obi_wdata_o  = (reset_ni && w_req) ? w_sel_wdata : '0;
  assign obi_be_o     = (reset_ni && w_req) ? w_sel_be : '0;
  assign obi_rready_o = w_rready;
  assign rdata_o      = obi_rdata_i;
  assign err_o        = obi_err_i;
  assign owner_o      = r_owner;
  assign busy_o       = (r_state != IDLE);
  assign err_cnt_o    = r_err_cnt;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_ni) begin
      assert ($onehot0(gnt_o));
      assert ($onehot0(rvalid_o));
    end
  end
`endif

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Scoreboard bench for obi_rr_arbiter: directed transactions push expected
// grants/responses, a negedge monitor pops and compares on each DUT event.
module tb_obi_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset_ni;
  logic [N-1:0]    req_i, we_i, rready_i;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wdata_i;
  logic [N*4-1:0]  be_i;
  logic [N-1:0]    gnt_o, rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic            err_o;
  logic            obi_req_o, obi_we_o;
  logic [AW-1:0]   obi_addr_o;
  logic [DW-1:0]   obi_wdata_o;
  logic [3:0]      obi_be_o;
  logic            obi_gnt_i, obi_rvalid_i, obi_rready_o;
  logic [DW-1:0]   obi_rdata_i;
  logic            obi_err_i;
  logic [1:0]      owner_o;
  logic            busy_o;
  logic [7:0]      err_cnt_o;

  obi_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .rready_i(rready_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .obi_req_o(obi_req_o),
    .obi_we_o(obi_we_o), .obi_addr_o(obi_addr_o), .obi_wdata_o(obi_wdata_o),
    .obi_be_o(obi_be_o), .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i),
    .obi_rready_o(obi_rready_o), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
    .owner_o(owner_o), .busy_o(busy_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
  } gexp_t;

  typedef struct {
    logic [N-1:0]  rvalid;
    logic [DW-1:0] rdata;
    logic          err;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one pop per grant and per completed response handshake.
  always @(negedge clk) begin
    if (reset_ni) begin
      if (gnt_o != '0) begin
        if (gq.size() == 0) check("gnt_unexpected", 64'(gnt_o), 64'd0);
        else begin
          gexp_t g;
          g = gq.pop_front();
          check("gnt_vec", 64'(gnt_o), 64'(g.gnt));
          check("gnt_req", 64'(obi_req_o), 64'd1);
          check("gnt_we", 64'(obi_we_o), 64'(g.we));
          check("gnt_addr", 64'(obi_addr_o), 64'(g.addr));
          check("gnt_wdata", 64'(obi_wdata_o), 64'(g.wdata));
          check("gnt_be", 64'(obi_be_o), 64'(g.be));
        end
      end
      if (rvalid_o != '0 && obi_rready_o) begin
        if (rq.size() == 0) check("rsp_unexpected", 64'(rvalid_o), 64'd0);
        else begin
          rexp_t r;
          r = rq.pop_front();
          check("rsp_rvalid", 64'(rvalid_o), 64'(r.rvalid));
          check("rsp_rdata", 64'(rdata_o), 64'(r.rdata));
          check("rsp_err", 64'(err_o), 64'(r.err));
        end
      end
    end
  end

  task automatic push_gnt(input int idx, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [3:0] be);
    gexp_t g;
    g.gnt = N'(1 << idx); g.we = we; g.addr = addr; g.wdata = wdata; g.be = be;
    gq.push_back(g);
  endtask

  task automatic push_rsp(input int idx, input logic [DW-1:0] rdata, input logic err);
    rexp_t r;
    r.rvalid = N'(1 << idx); r.rdata = rdata; r.err = err;
    rq.push_back(r);
  endtask

  task automatic set_req(input int idx, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [3:0] be);
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    req_i[idx] = 1'b1;
    we_i[idx] = we;
    addr_i[idx*AW +: AW] = addr;
    wdata_i[idx*DW +: DW] = wdata;
    be_i[idx*4 +: 4] = be;
  endtask

  // Single-requester transaction with gwait cycles of grant delay.
  task automatic do_txn(input int idx, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [3:0] be, input int gwait,
                        input logic [DW-1:0] rdata, input logic err);
    @(posedge clk); #1;
    set_req(idx, we, addr, wdata, be);
    rready_i = '1;
    push_gnt(idx, we, addr, wdata, be);
    obi_gnt_i = (gwait == 0);
    for (int w = 0; w < gwait; w++) @(posedge clk);
    if (gwait > 0) begin #1; obi_gnt_i = 1'b1; end
    @(posedge clk); #1;
    obi_gnt_i = 1'b0; req_i = '0;
    obi_rvalid_i = 1'b1; obi_rdata_i = rdata; obi_err_i = err;
    push_rsp(idx, rdata, err);
    @(posedge clk); #1;
    obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_ni = 1'b0;
    req_i = '1; we_i = '1; rready_i = '1; wdata_i = '1; be_i = '1;
    for (int k = 0; k < N; k++) addr_i[k*AW +: AW] = 32'hA000_0000 | k;
    obi_gnt_i = 1'b1; obi_rvalid_i = 1'b0; obi_rdata_i = '0; obi_err_i = 1'b0;

    // Reset with all requests asserted: everything quiet.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_req", 64'(obi_req_o), 64'd0);
    check("rst_we", 64'(obi_we_o), 64'd0);
    check("rst_addr", 64'(obi_addr_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_errcnt", 64'(err_cnt_o), 64'd0);
    check("rst_owner", 64'(owner_o), 64'd0);
    @(posedge clk); #1;
    reset_ni = 1'b1;
    req_i = '0; we_i = '0; wdata_i = '0; be_i = '0; obi_gnt_i = 1'b0;
    @(negedge clk);
    check("idle_req", 64'(obi_req_o), 64'd0);
    check("idle_addr", 64'(obi_addr_o), 64'd0);

    // All four requesting, zero-wait grant and response: 0,1,2,3,0 in 10 cycles.
    @(posedge clk); #1;
    req_i = '1; obi_gnt_i = 1'b1; obi_rvalid_i = 1'b1; obi_rdata_i = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      push_gnt(i % 4, 1'b0, 32'hA000_0000 | (i % 4), 32'h0, 4'h0);
      push_rsp(i % 4, 32'h1234_5678, 1'b0);
    end
    repeat (10) @(posedge clk);
    #1;
    req_i = '0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0;
    @(negedge clk);
    check("rr_gq_empty", 64'(gq.size()), 64'd0);
    check("rr_rq_empty", 64'(rq.size()), 64'd0);
    check("rr_busy", 64'(busy_o), 64'd0);
    check("rr_owner", 64'(owner_o), 64'd0);

    // Requester 1 alone, grant after 3 wait cycles: address held stable.
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    rready_i = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("wait_req", 64'(obi_req_o), 64'd1);
      check("wait_addr", 64'(obi_addr_o), 64'h1000);
      check("wait_gnt", 64'(gnt_o), 64'd0);
      @(posedge clk);
    end
    #1;
    obi_gnt_i = 1'b1;
    push_gnt(1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    @(posedge clk); #1;
    obi_gnt_i = 1'b0; req_i = '0;
    @(negedge clk);
    check("resp_noreq", 64'(obi_req_o), 64'd0);
    check("resp_busy", 64'(busy_o), 64'd1);
    check("resp_owner", 64'(owner_o), 64'd1);
    @(posedge clk); #1;
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'h5555_AAAA;
    push_rsp(1, 32'h5555_AAAA, 1'b0);
    @(posedge clk); #1;
    obi_rvalid_i = 1'b0;

    // Write from requester 3, then a read returned to requester 0.
    do_txn(3, 1'b1, 32'h3000_0030, 32'hDEAD_BEEF, 4'b0011, 0, 32'h0, 1'b0);
    do_txn(0, 1'b0, 32'h0000_0040, 32'h0, 4'b1111, 1, 32'hCAFE_F00D, 1'b0);

    // Response backpressure: rready_i[0] low for two cycles.
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0000_0080, 32'h0, 4'hF);
    rready_i = '0; obi_gnt_i = 1'b1;
    push_gnt(0, 1'b0, 32'h0000_0080, 32'h0, 4'hF);
    @(posedge clk); #1;
    obi_gnt_i = 1'b0; req_i = '0; obi_rvalid_i = 1'b1; obi_rdata_i = 32'h7777_0000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("bp_rready", 64'(obi_rready_o), 64'd0);
      check("bp_rvalid", 64'(rvalid_o), 64'b0001);
      check("bp_busy", 64'(busy_o), 64'd1);
      @(posedge clk);
    end
    #1;
    rready_i = 4'b0001;
    push_rsp(0, 32'h7777_0000, 1'b0);
    @(posedge clk); #1;
    obi_rvalid_i = 1'b0; rready_i = '1;
    @(negedge clk);
    check("bp_done_busy", 64'(busy_o), 64'd0);

    // 260 error responses across all owners: counter saturates.
    for (int i = 0; i < 260; i++) begin
      do_txn(i % 4, i[0], 32'h100 + i * 4, 32'(i), 4'hF, i % 3, 32'hE000_0000 + i, 1'b1);
      if (i == 0)   check("errcnt_1", 64'(err_cnt_o), 64'd1);
      if (i == 254) check("errcnt_255", 64'(err_cnt_o), 64'hFF);
    end
    check("errcnt_sat", 64'(err_cnt_o), 64'hFF);

    // Reset in the middle of a response phase owned by requester 2.
    @(posedge clk); #1;
    set_req(2, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
    obi_gnt_i = 1'b1;
    push_gnt(2, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
    @(posedge clk); #1;
    obi_gnt_i = 1'b0; req_i = '0;
    @(negedge clk);
    check("mid_busy", 64'(busy_o), 64'd1);
    check("mid_owner", 64'(owner_o), 64'd2);
    @(posedge clk); #1;
    reset_ni = 1'b0;
    @(posedge clk); #1;
    reset_ni = 1'b1; obi_rvalid_i = 1'b1; obi_rdata_i = 32'hBAD0_0000;
    @(negedge clk);
    check("mrst_busy", 64'(busy_o), 64'd0);
    check("mrst_errcnt", 64'(err_cnt_o), 64'd0);
    check("mrst_owner", 64'(owner_o), 64'd0);
    check("mrst_rvalid", 64'(rvalid_o), 64'd0);
    check("mrst_rready", 64'(obi_rready_o), 64'd1);
    @(posedge clk); #1;
    obi_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("end_gq_empty", 64'(gq.size()), 64'd0);
    check("end_rq_empty", 64'(rq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Shares one OBI manager port between NUM_REQ requesters, e.g. several obi_master instances or controllers, in front of a single subordinate.
- Round-robin arbitration with at most one outstanding transaction: address phase, then response phase, then re-arbitrate.
- Routes the response (rdata/err/rvalid) back to the owning requester.
- Keeps a saturating error-response counter.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ADDR_WIDTH, 32, address width (32 or 64).
- DATA_WIDTH, 32, data width (32 or 64).
- IDX_W, $clog2(NUM_REQ), requester index width (localparam).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- reset_ni  in  1  reset; synchronous, active-low.
- req_i  in  NUM_REQ  per-requester OBI req.
- we_i  in  NUM_REQ  per-requester write enable.
- addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- wdata_i  in  NUM_REQ*DATA_WIDTH  packed write data.
- be_i  in  NUM_REQ*DATA_WIDTH/8  packed byte enables.
- rready_i  in  NUM_REQ  per-requester rready.
- gnt_o  out  NUM_REQ  one-hot grant.
- rvalid_o  out  NUM_REQ  one-hot response valid.
- rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters.
- err_o  out  1  response error, broadcast.
- obi_req_o, obi_we_o  out  1  downstream A channel.
- obi_addr_o  out  ADDR_WIDTH  downstream address.
- obi_wdata_o  out  DATA_WIDTH  downstream write data.
- obi_be_o  out  DATA_WIDTH/8  downstream byte enables.
- obi_gnt_i  in  1  downstream grant.
- obi_rvalid_i  in  1  downstream response valid.
- obi_rready_o  out  1  downstream response ready.
- obi_rdata_i  in  DATA_WIDTH  downstream response data.
- obi_err_i  in  1  downstream response error.
- owner_o  out  IDX_W  current or last owner index.
- busy_o  out  1  high in ADDR or RESP.
- err_cnt_o  out  8  count of error responses, saturating at 8'hFF.

Behaviour:
- Reset (reset_ni low at a clock edge): state=IDLE, prio_q=0, owner_q=0, err_cnt=0. Reset is applied even mid-transaction; the in-flight transaction is abandoned.
- While in reset, and in IDLE with no request: all gnt_o/rvalid_o=0, obi_req_o=0, obi_we_o=0, obi_addr_o/obi_wdata_o/obi_be_o=0.
- Arbitration: winner = first k with req_i[k]=1, searching prio_q, prio_q+1, ... modulo NUM_REQ.
- IDLE:
  - If any req_i: drive winner's we/addr/wdata/be downstream and set obi_req_o=1 in the same cycle.
  - owner_q<=winner; prio_q<=(winner+1) mod NUM_REQ.
  - If obi_gnt_i=1 in the same cycle: gnt_o[winner]=1, go to RESP (zero-wait grant).
  - Otherwise go to ADDR.
- ADDR:
  - obi_req_o held 1; fields come live from owner_q.
  - No re-arbitration; other requesters' req_i are ignored.
  - On obi_gnt_i: gnt_o[owner_q]=1 for exactly that cycle, go to RESP.
  - A requester retracting req in ADDR is a protocol violation. The arbiter still holds obi_req_o and grants the stale request.
- RESP:
  - obi_req_o=0; obi_rready_o=rready_i[owner_q].
  - rvalid_o[owner_q]=obi_rvalid_i; rdata_o=obi_rdata_i; err_o=obi_err_i.
  - On obi_rvalid_i & obi_rready_o: go to IDLE. If obi_err_i is also set, err_cnt increments unless already 8'hFF.
- Throughput: one transaction per (2 + grant wait + response wait) cycles minimum. There is always one IDLE cycle between transactions.
- IDLE and ADDR: obi_rready_o=1 so stray responses (e.g. after reset) drain. These are not routed, rvalid_o stays 0, and they are not counted.
- gnt_o and rvalid_o are each one-hot or zero every cycle.
- rdata_o/err_o outside RESP: pass obi_rdata_i/obi_err_i through; they are meaningless without rvalid_o.
- owner_o=owner_q; busy_o=(state!=IDLE).
- prio_q wraps from NUM_REQ-1 to 0. A single requester requesting continuously is granted every transaction (no starvation of a lone requester).

Decomposition:
- Package obi_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_e {IDLE=2'b00, ADDR=2'b01, RESP=2'b10}.
  - ERR_CNT_W=8.
- One sub-module: obi_rr_select. It is purely combinational and parameterised on NUM_REQ.
  - Inputs: req vector and prio index.
  - Outputs: valid, winner index, one-hot winner.

Test Plan:
- Reset mid-RESP (requester 2 owning) -> next cycle IDLE, busy_o=0, err_cnt_o=0; a late obi_rvalid_i gives rvalid_o=4'b0000.
- req_i=4'b1111 held, obi_gnt_i and obi_rvalid_i immediate -> grants in order 0,1,2,3,0; each transaction takes 2 cycles.
- req_i[1] only, addr=32'h0000_1000, obi_gnt_i delayed 3 cycles -> obi_req_o high 4 cycles with addr stable; gnt_o=4'b0010 only on the gnt cycle.
- Requester 3 write, wdata=32'hDEAD_BEEF, be=4'b0011 -> obi_we_o=1, obi_wdata_o=32'hDEAD_BEEF, obi_be_o=4'b0011; read rdata=32'hCAFE_F00D to requester 0 -> rvalid_o=4'b0001.
- Owner 0 with rready_i[0]=0 for 2 cycles while obi_rvalid_i=1 -> stays RESP, obi_rready_o=0; completes on the cycle rready_i[0]=1.
- 260 responses with obi_err_i=1 -> err_cnt_o saturates at 8'hFF; err_o is seen by each owner.
